// File: rtl/generic_step_counter_bank.sv
// Bank of CHANNELS independent WIDTH-bit counters advanced by per-request steps,
// with a valid/ready request port and a one-deep registered response stage.
// Build option: define GENERIC_STEP_COUNTER_SAT_EN for saturating counters (default wraps).
module generic_step_counter_bank #(
  parameter int WIDTH      = 10,
  parameter int STEP_WIDTH = 4,
  parameter int CHANNELS   = 4,
  parameter int CH_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [CH_WIDTH-1:0]   i_req_ch,
  input  logic [STEP_WIDTH-1:0] i_req_step,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [CH_WIDTH-1:0]   o_rsp_ch,
  output logic [WIDTH-1:0]      o_rsp_value,
  output logic                  o_rsp_ovf,
  output logic                  o_rsp_err
);

  localparam logic [CH_WIDTH:0] CH_LIMIT = (CH_WIDTH+1)'(CHANNELS);

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cur_cnt;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    upd_value;
  logic                upd_ovf;
  logic                accept;
  logic                ch_ok;

  logic                rsp_valid_reg;
  logic [CH_WIDTH-1:0] rsp_ch_reg;
  logic [WIDTH-1:0]    rsp_value_reg;
  logic                rsp_ovf_reg;
  logic                rsp_err_reg;

  // Clear blocks new requests so a cleared counter is never updated in the same edge.
  assign o_req_ready = !i_clr && (!rsp_valid_reg || i_rsp_ready);
  assign accept      = i_req_valid && o_req_ready;
  assign ch_ok       = ({1'b0, i_req_ch} < CH_LIMIT);

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_req_ch == CH_WIDTH'(i)) begin
        cur_cnt = cnt_q[i];
      end
    end
  end

  assign sum = {1'b0, cur_cnt} + (WIDTH+1)'(i_req_step);

`ifdef GENERIC_STEP_COUNTER_SAT_EN
  assign upd_value = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign upd_ovf   = sum[WIDTH];
`else
  assign upd_value = sum[WIDTH-1:0];
  assign upd_ovf   = sum[WIDTH];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] cnt_reg;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          cnt_reg <= '0;
        end else if (i_clr) begin
          cnt_reg <= '0;
        end else if (accept && ch_ok && (i_req_ch == CH_WIDTH'(gi))) begin
          cnt_reg <= upd_value;
        end
      end

      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  // Response is held until the consumer takes it; a new accept overwrites it in the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_ch_reg    <= '0;
      rsp_value_reg <= '0;
      rsp_ovf_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_ch_reg    <= i_req_ch;
      rsp_value_reg <= ch_ok ? upd_value : '0;
      rsp_ovf_reg   <= ch_ok && upd_ovf;
      rsp_err_reg   <= !ch_ok;
    end else if (i_rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_ch    = rsp_ch_reg;
  assign o_rsp_value = rsp_value_reg;
  assign o_rsp_ovf   = rsp_ovf_reg;
  assign o_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_generic_step_counter_bank.sv
// Directed bench for generic_step_counter_bank (WIDTH=10, STEP_WIDTH=4, CHANNELS=3)
// with a transaction-level model and literal expectations checked at each falling edge.
module tb_generic_step_counter_bank;

  localparam int WIDTH = 10;
  localparam int SW    = 4;
  localparam int NCH   = 3;
  localparam int CHW   = 2;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_clr = 1'b0;
  logic             i_req_valid = 1'b0;
  logic             o_req_ready;
  logic [CHW-1:0]   i_req_ch = '0;
  logic [SW-1:0]    i_req_step = '0;
  logic             o_rsp_valid;
  logic             i_rsp_ready = 1'b1;
  logic [CHW-1:0]   o_rsp_ch;
  logic [WIDTH-1:0] o_rsp_value;
  logic             o_rsp_ovf;
  logic             o_rsp_err;

  generic_step_counter_bank #(
    .WIDTH(WIDTH), .STEP_WIDTH(SW), .CHANNELS(NCH), .CH_WIDTH(CHW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_ch(i_req_ch), .i_req_step(i_req_step),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_ch(o_rsp_ch), .o_rsp_value(o_rsp_value),
    .o_rsp_ovf(o_rsp_ovf), .o_rsp_err(o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- behavioural model ----------------
  int          m_cnt [4];
  logic        m_valid = 1'b0;
  int          m_ch = 0;
  int          m_val = 0;
  logic        m_ovf = 1'b0;
  logic        m_err = 1'b0;
  logic [WIDTH:0] m_next;
  logic        m_ready;
  logic        m_acc;

  function automatic logic [WIDTH:0] upd(input int cur, input int st);
    int   total;
    int   v;
    logic ovf;
    total = cur + st;
    ovf   = (total > MAXV);
`ifdef GENERIC_STEP_COUNTER_SAT_EN
    v = ovf ? MAXV : total;
`else
    v = total % (MAXV + 1);
`endif
    return {ovf, v[WIDTH-1:0]};
  endfunction

  assign m_next  = upd(m_cnt[i_req_ch], int'(i_req_step));
  assign m_ready = !i_clr && (!m_valid || i_rsp_ready);
  assign m_acc   = i_req_valid && m_ready;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
      m_valid <= 1'b0;
      m_ch    <= 0;
      m_val   <= 0;
      m_ovf   <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      if (i_clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
      end
      if (m_acc) begin
        m_valid <= 1'b1;
        m_ch    <= int'(i_req_ch);
        if (int'(i_req_ch) >= NCH) begin
          m_val <= 0;
          m_ovf <= 1'b0;
          m_err <= 1'b1;
        end else begin
          m_cnt[i_req_ch] <= int'(m_next[WIDTH-1:0]);
          m_val <= int'(m_next[WIDTH-1:0]);
          m_ovf <= m_next[WIDTH];
          m_err <= 1'b0;
        end
      end else if (i_rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------- literal expectations ----------------
  logic  chk_en = 1'b0;
  logic  lit_en = 1'b0;
  string lit_name = "";
  logic  lit_valid, lit_rdy, lit_fields, lit_ovf, lit_err;
  int    lit_ch, lit_val;

  // ---------------- compare process ----------------
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("model_rsp_valid", int'(o_rsp_valid), int'(m_valid));
      chk("model_req_ready", int'(o_req_ready), int'(m_ready));
      if (m_valid) begin
        chk("model_rsp_ch", int'(o_rsp_ch), m_ch);
        chk("model_rsp_value", int'(o_rsp_value), m_val);
        chk("model_rsp_ovf", int'(o_rsp_ovf), int'(m_ovf));
        chk("model_rsp_err", int'(o_rsp_err), int'(m_err));
      end
      if (lit_en) begin
        chk({lit_name, "_valid"}, int'(o_rsp_valid), int'(lit_valid));
        chk({lit_name, "_ready"}, int'(o_req_ready), int'(lit_rdy));
        if (lit_fields) begin
          chk({lit_name, "_ch"}, int'(o_rsp_ch), lit_ch);
          chk({lit_name, "_value"}, int'(o_rsp_value), lit_val);
          chk({lit_name, "_ovf"}, int'(o_rsp_ovf), int'(lit_ovf));
          chk({lit_name, "_err"}, int'(o_rsp_err), int'(lit_err));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge i_clk);
    #2;
    lit_en = 1'b0;
  endtask

  task automatic drive(input int ch, input int st);
    i_req_valid = 1'b1;
    i_req_ch    = ch[CHW-1:0];
    i_req_step  = st[SW-1:0];
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string nm, input logic v, input logic rdy, input logic fields,
                            input int ch, input int val, input logic ovf, input logic err);
    lit_name   = nm;
    lit_valid  = v;
    lit_rdy    = rdy;
    lit_fields = fields;
    lit_ch     = ch;
    lit_val    = val;
    lit_ovf    = ovf;
    lit_err    = err;
    lit_en     = 1'b1;
  endtask

  // One response check right after an accepting edge.
  task automatic issue(input string nm, input int ch, input int st,
                       input int val, input logic ovf, input logic err);
    drive(ch, st);
    tick();
    expect_rsp(nm, 1'b1, 1'b1, 1'b1, ch, val, ovf, err);
  endtask

  initial begin
    #1;
    i_rst  = 1'b1;
    chk_en = 1'b1;
    tick();
    expect_rsp("reset", 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    i_rst = 1'b0;

    // Reset while a response is pending.
    i_rsp_ready = 1'b0;
    drive(0, 4);
    tick();
    idle();
    expect_rsp("pend", 1'b1, 1'b0, 1'b1, 0, 4, 1'b0, 1'b0);
    tick();
    expect_rsp("pend_hold", 1'b1, 1'b0, 1'b1, 0, 4, 1'b0, 1'b0);
    #1;
    i_rst = 1'b1;
    expect_rsp("rst_mid", 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    i_rst = 1'b0;
    i_rsp_ready = 1'b1;
    issue("after_rst", 0, 1, 1, 1'b0, 1'b0);
    idle();
    tick();

    // Back-to-back same-channel accepts.
    issue("burst_a", 2, 3, 3, 1'b0, 1'b0);
    issue("burst_b", 2, 3, 6, 1'b0, 1'b0);
    issue("burst_c", 2, 3, 9, 1'b0, 1'b0);
    idle();
    tick();

    // Climb to the overflow boundary.
    for (int k = 0; k < 68; k++) begin
      issue("climb", 1, 15, 15 * (k + 1), 1'b0, 1'b0);
    end
`ifdef GENERIC_STEP_COUNTER_SAT_EN
    issue("ovf_step", 1, 15, 1023, 1'b1, 1'b0);
    issue("ovf_after", 1, 1, 1023, 1'b1, 1'b0);
`else
    issue("ovf_step", 1, 15, 11, 1'b1, 1'b0);
    issue("ovf_after", 1, 1, 12, 1'b0, 1'b0);
`endif
    idle();
    tick();

    // Backpressure: response held, request stalls until the consumer is ready.
    i_rsp_ready = 1'b0;
    drive(0, 2);
    tick();
    drive(0, 5);
    expect_rsp("bp_first", 1'b1, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    tick();
    expect_rsp("bp_hold1", 1'b1, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    tick();
    expect_rsp("bp_hold2", 1'b1, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    tick();
    i_rsp_ready = 1'b1;
    expect_rsp("bp_release", 1'b1, 1'b1, 1'b1, 0, 3, 1'b0, 1'b0);
    tick();
    idle();
    expect_rsp("bp_next", 1'b1, 1'b1, 1'b1, 0, 8, 1'b0, 1'b0);
    tick();

    // Out-of-range channel, then confirm the real counters are untouched.
    issue("bad_ch", 3, 5, 0, 1'b0, 1'b1);
    issue("keep_ch0", 0, 0, 8, 1'b0, 1'b0);
`ifdef GENERIC_STEP_COUNTER_SAT_EN
    issue("keep_ch1", 1, 0, 1023, 1'b0, 1'b0);
`else
    issue("keep_ch1", 1, 0, 12, 1'b0, 1'b0);
`endif
    issue("keep_ch2", 2, 0, 9, 1'b0, 1'b0);
    idle();
    tick();

    // Clear blocks the concurrent request, which then lands on a zeroed counter.
    i_clr = 1'b1;
    drive(2, 2);
    expect_rsp("clr_block", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    i_clr = 1'b0;
    expect_rsp("clr_no_acc", 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    idle();
    expect_rsp("after_clr", 1'b1, 1'b1, 1'b1, 2, 2, 1'b0, 1'b0);
    tick();
    issue("clr_ch0", 0, 0, 0, 1'b0, 1'b0);
    issue("clr_ch1", 1, 1, 1, 1'b0, 1'b0);
    idle();
    tick();

    // Clear leaves a pending response intact.
    i_rsp_ready = 1'b0;
    drive(0, 3);
    tick();
    idle();
    i_clr = 1'b1;
    expect_rsp("clr_pend", 1'b1, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    tick();
    i_clr = 1'b0;
    expect_rsp("clr_keep", 1'b1, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    tick();
    i_rsp_ready = 1'b1;
    tick();
    expect_rsp("clr_drop", 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    issue("clr_ch0_zero", 0, 0, 0, 1'b0, 1'b0);
    idle();
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
